uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART 8N1 receiver; downstream partner of uart_tx, same BAUD_CNT meaning.
//   Samples the async serial line `rx` mid-bit and emits each byte as a 1-cycle valid pulse.
//   Flags a bad stop bit. Sits between the board RX pin and the byte consumer; no backpressure.
// PARAMETERS
//   BAUD_CNT  434  clk cycles per bit (50 MHz / 115200). Legal range: BAUD_CNT >= 4.
// PORTS
//   clk        input   1  system clock, all logic on rising edge
//   rst        input   1  synchronous, active-high reset
//   rx         input   1  async serial input, idles high
//   data       output  8  last correctly received byte
//   valid      output  1  1-cycle pulse: new byte on data
//   frame_err  output  1  1-cycle pulse: stop bit sampled low
//   busy       output  1  high while not in IDLE
// BEHAVIOUR
//   Reset values: data=8'h00, valid=0, frame_err=0, busy=0.
//     Sync flops and edge-detect flop reset to 1. State=IDLE, counters=0.
//   Synchroniser: rx -> 2 flops -> rx_s. Edge detect: rx_d = rx_s delayed 1 clk.
//   Counters: cnt is $clog2(BAUD_CNT) bits; bit_idx is 3 bits; shift register sh is 8 bits.
//   FSM states: IDLE, START, DATA, STOP.
//     IDLE : falling edge (rx_d=1 & rx_s=0) -> START, cnt=0.
//            A line held low does not retrigger; it needs 1 then 0.
//     START: cnt increments. At cnt==BAUD_CNT/2-1, sample rx_s:
//              rx_s=0 -> DATA, cnt=0, bit_idx=0
//              rx_s=1 -> IDLE (glitch rejected, no pulse)
//     DATA : cnt increments. At cnt==BAUD_CNT-1: cnt=0, sh={rx_s,sh[7:1]} (LSB first), bit_idx++.
//            After the 8th sample (bit_idx==7) -> STOP.
//     STOP : at cnt==BAUD_CNT-1 sample rx_s:
//              1 -> data<=sh, valid=1 next cycle
//              0 -> frame_err=1 next cycle, data unchanged
//            Either way -> IDLE.
//   Timing: E = first cycle rx_s==0 with rx_d==1.
//     Start sampled at E+BAUD_CNT/2; data bit k at E+BAUD_CNT/2+(k+1)*BAUD_CNT.
//     Stop sampled at E+BAUD_CNT/2+9*BAUD_CNT; valid/frame_err high the following cycle.
//   busy: registered (state!=IDLE), i.e. 1 clk behind the state.
//   valid and frame_err: never high together; each stays high exactly one cycle.
//   Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge one stop bit later is caught.
//   No backpressure: a new byte overwrites data; the consumer must capture on valid.
//   rst mid-frame: frame aborted, no pulse, all state returns to reset values next clk.
// TESTING (BAUD_CNT=10, clk period 20 ns)
//   1. Frame 0xB9 (bits 1,0,0,1,1,1,0,1, stop=1) -> one valid pulse; data=0xB9; frame_err never 1.
//   2. 0x00 then 0xFF, 1 stop bit between -> two valid pulses exactly 100 clk apart; data 0x00 then 0xFF.
//   3. Idle line pulsed low 3 clk -> busy rises then falls; no valid, no frame_err; next frame 0x5A received OK.
//   4. Frame 0x55 with stop=0, line held low 50 clk then high -> one frame_err pulse, no valid,
//      data keeps previous value, no second frame until a new falling edge.
//   5. rst for 1 clk during bit 4 of 0xA5 -> valid/busy 0 next clk; then full frame 0x3C -> data=0x3C, valid once.
//   6. Loopback uart_tx.tx->rx, both BAUD_CNT=10; send 0xB9 then 0x0F -> data 0xB9 then 0x0F,
//      frame_err never asserted.

Source files
------------

// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop synchroniser, falling-edge start detect,
// mid-bit sampling, one-cycle valid / frame_err pulses and a busy flag.
`timescale 1ns/1ps

module uart_rx #(
  parameter int BAUD_CNT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_CNT);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_CNT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic          rx_meta;
  logic          rx_s;
  logic          rx_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_d;
  logic          valid_d;
  logic          frame_err_d;

  // Synchroniser and edge-detect flops reset high so a released reset on an
  // idle line never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      busy      <= (state_q != IDLE);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    sh_d        = sh_q;
    data_d      = data;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Requires a 1 -> 0 transition; a line stuck low cannot retrigger.
        if (rx_d && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          sh_d      = {rx_s, sh_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        // Leave mid-stop-bit so a start edge right after one stop bit is seen.
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected pulses, a negedge
// monitor pops and compares whenever valid or frame_err fires.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int BAUD = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.BAUD_CNT(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  typedef enum logic {EV_VALID, EV_FERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_e;
  int         valid_cyc[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] last_good = 8'h00;
  logic       saw_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    ev_t e;
    if (stop_bit) begin
      e.kind    = EV_VALID;
      e.data    = b;
      last_good = b;
    end else begin
      e.kind = EV_FERR;
      e.data = last_good;
    end
    sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check(name, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst && (valid || frame_err)) begin
      check("pulse_exclusive", 32'(valid & frame_err), 32'd0);
      if (valid) valid_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=0x%0h, expected no pulse",
                 valid, frame_err, data);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_ferr", 32'(frame_err), 32'(mon_e.kind == EV_FERR));
        check("pulse_data", 32'(data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",      32'(data),      32'h00);
    check("reset_valid",     32'(valid),     32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single frame
    send_frame(8'hB9, 1'b1);
    drain("t1_drain");
    check("t1_data", 32'(data), 32'hB9);
    repeat (20) @(negedge clk);

    // 2: back-to-back with a single stop bit, pulses one frame apart
    valid_cyc.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drain("t2_drain");
    check("t2_valid_count", 32'(valid_cyc.size()), 32'd2);
    if (valid_cyc.size() == 2)
      check("t2_pulse_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'd100);
    check("t2_data", 32'(data), 32'hFF);
    repeat (20) @(negedge clk);

    // 3: short glitch is rejected, next frame still received
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    check("t3_busy_rose", 32'(saw_busy), 32'd1);
    check("t3_busy_fell", 32'(busy), 32'd0);
    send_frame(8'h5A, 1'b1);
    drain("t3_drain");
    check("t3_data", 32'(data), 32'h5A);
    repeat (20) @(negedge clk);

    // 4: bad stop bit, line held low must not retrigger
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_no_retrigger_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    drain("t4_drain");
    check("t4_data_kept", 32'(data), 32'h5A);
    check("t4_idle_busy", 32'(busy), 32'd0);

    // 5: reset in the middle of bit 4 of 0xA5
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hA5 >> i));
    rx = 1'b0;
    repeat (BAUD / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check("t5_valid_after_rst", 32'(valid), 32'd0);
    check("t5_busy_after_rst",  32'(busy),  32'd0);
    check("t5_data_after_rst",  32'(data),  32'h00);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (30) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    drain("t5_drain");
    check("t5_data", 32'(data), 32'h3C);
    repeat (20) @(negedge clk);

    // 6: transmitter-shaped stream, two frames back to back
    send_frame(8'hB9, 1'b1);
    send_frame(8'h0F, 1'b1);
    rx = 1'b1;
    drain("t6_drain");
    check("t6_data", 32'(data), 32'h0F);
    repeat (20) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
